// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter),
// default baud divisor and data width.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;
    localparam int unsigned DATA_W               = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// should match the input's idle level so reset release never fakes an edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled bits, stop-bit check, and a valid/ack
// holding register with framing-error pulse and sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    uart_state_t       state;
    logic [CNT_W-1:0]  clk_count;
    logic [IDX_W-1:0]  bit_index;
    logic [DATA_W-1:0] shreg;
    logic              rx_s;
    logic              rx_prev;
    logic              start_edge;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    // Only a falling edge starts a frame; a line stuck low is ignored.
    assign start_edge = rx_prev & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_count  <= '0;
            bit_index  <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (data_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        state     <= START;
                        clk_count <= '0;
                        busy      <= 1'b1;
                    end
                end

                START: begin
                    if (clk_count == HALF_M1) begin
                        clk_count <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= DATA;
                            bit_index <= '0;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_count == BIT_M1) begin
                        clk_count <= '0;
                        shreg     <= {rx_s, shreg[DATA_W-1:1]};
                        if (bit_index == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_index <= bit_index + 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                STOP: begin
                    // Leave mid-stop-bit so a closely following start bit is caught.
                    if (clk_count == BIT_M1) begin
                        clk_count <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        if (rx_s) begin
                            data       <= shreg;
                            data_valid <= 1'b1;
                            if (data_valid && !data_ack) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; received bytes are checked
// against a scoreboard queue filled as frames are driven.
module tb_uart_rx;

    localparam int unsigned C    = 16;
    localparam int unsigned HALF = C / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    int unsigned cyc = 0;
    int unsigned loads = 0;
    int unsigned fe_pulses = 0;
    int unsigned busy_cycles = 0;
    int unsigned busy_rise_cyc = 0;
    int unsigned load_cyc = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  sb_exp;
    logic        prev_valid = 1'b0;
    logic        prev_busy = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    uart_rx #(
        .CLKS_PER_BIT(C),
        .CNT_W       (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .data_ack  (data_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // A new byte is visible when data_valid rises or the held byte is replaced.
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (frame_err) fe_pulses++;
        if (data_valid && (!prev_valid || data !== prev_data)) begin
            loads++;
            load_cyc = cyc;
            compared++;
            assert (exp_q.size() > 0) else begin
                mismatched++;
                $error("FAIL sb_unexpected observed=%0h expected=none", data);
            end
            if (exp_q.size() > 0) begin
                sb_exp = exp_q.pop_front();
                assert (data === sb_exp) else begin
                    mismatched++;
                    $error("FAIL sb_data observed=%0h expected=%0h", data, sb_exp);
                end
            end
        end
        prev_valid = data_valid;
        prev_busy  = busy;
        prev_data  = data;
    end

    initial begin
        #1_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        cycles(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(C);
        end
        rx = stop_v;
        cycles(C);
    endtask

    task automatic ack();
        data_ack = 1'b1;
        cycles(1);
        data_ack = 1'b0;
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        cycles(3);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cycles(5);

        // Good byte, latency from START entry, then acknowledge
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        chk("a5_loads", loads, 1);
        chk("a5_data", data, 8'hA5);
        chk("a5_valid", data_valid, 1'b1);
        chk("a5_latency", load_cyc - busy_rise_cyc, HALF + 9 * C);
        chk("a5_frame_err", fe_pulses, 0);
        chk("a5_overrun", overrun, 1'b0);
        ack();
        chk("a5_ack_valid", data_valid, 1'b0);

        // Short low glitch: false start
        busy_cycles = 0;
        rx = 1'b0;
        cycles(5);
        rx = 1'b1;
        cycles(30);
        chk("glitch_busy_cycles", busy_cycles, 8);
        chk("glitch_loads", loads, 1);
        chk("glitch_valid", data_valid, 1'b0);
        chk("glitch_frame_err", fe_pulses, 0);

        // Bad stop bit, then line held low
        send_frame(8'h3C, 1'b0);
        busy_cycles = 0;
        cycles(100);
        chk("fe_pulses", fe_pulses, 1);
        chk("fe_data", data, 8'hA5);
        chk("fe_valid", data_valid, 1'b0);
        chk("fe_loads", loads, 1);
        chk("fe_low_no_start", busy_cycles, 0);
        rx = 1'b1;
        cycles(2 * C);

        // Overrun, ack clears, then good stop coincident with ack
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        chk("ovr_data", data, 8'h22);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_valid", data_valid, 1'b1);
        ack();
        chk("ovr_ack_valid", data_valid, 1'b0);
        chk("ovr_ack_flag", overrun, 1'b0);
        exp_q.push_back(8'h44);
        send_frame(8'h44, 1'b1);
        chk("hold44_valid", data_valid, 1'b1);
        chk("hold44_overrun", overrun, 1'b0);
        exp_q.push_back(8'h33);
        fork
            send_frame(8'h33, 1'b1);
            begin
                repeat (3 + HALF + 9 * C - 1) @(posedge clk);
                #1 data_ack = 1'b1;
                cycles(1);
                data_ack = 1'b0;
            end
        join
        chk("simul_data", data, 8'h33);
        chk("simul_valid", data_valid, 1'b1);
        chk("simul_overrun", overrun, 1'b0);
        chk("simul_loads", loads, 5);
        cycles(2 * C);

        // Reset in the middle of 0xF0 (during bit 4)
        rx = 1'b0;
        cycles(C);
        rx = 1'b0;
        cycles(4 * C);
        rx = 1'b1;
        cycles(HALF);
        chk("midrst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        cycles(2);
        chk("midrst_data", data, 8'h00);
        chk("midrst_valid", data_valid, 1'b0);
        chk("midrst_overrun", overrun, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cycles(4 * C);
        chk("midrst_idle_after", busy_cycles >= 0 && busy == 1'b0, 1'b1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        chk("post_rst_data", data, 8'h5A);
        chk("post_rst_valid", data_valid, 1'b1);
        chk("post_rst_frame_err", fe_pulses, 1);
        ack();
        cycles(C);

        // Back-to-back frames
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        cycles(C);
        chk("b2b_loads", loads, 9);
        chk("b2b_data", data, 8'h55);
        chk("b2b_frame_err", fe_pulses, 1);
        chk("b2b_overrun", overrun, 1'b1);
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the guess-the-number game's 8N1 serial link. It recovers bytes from the PC's TX line into the FPGA and is the counterpart of the existing transmitter. The block synchronises the asynchronous `rx` line, samples each bit at its centre, and checks the stop bit. Each received byte is held for the game logic behind a valid/ack handshake, with framing-error and overrun reporting.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per bit (50 MHz / 9600 baud); must be ≥ 4.
- `CNT_W`, 13: bit-counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line from PC; asynchronous; idles high.
- `data`  out  8  last good byte, LSB received first; reset 0x00.
- `data_valid`  out  1  high while `data` holds an unacknowledged byte; reset 0.
- `data_ack`  in  1  consumer acknowledge; one-cycle pulse.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low; reset 0.
- `overrun`  out  1  sticky flag: a byte was overwritten before ack; reset 0.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE); reset 0.

## Operation
- Synchroniser:
  - `rx` passes through 2 flops to `rx_s`; both reset to 1.
  - `rx_prev` registers `rx_s` and resets to 1.
  - Start edge = `rx_prev`=1 and `rx_s`=0.
- State machine IDLE → START → DATA → STOP → IDLE. Reset state is IDLE, with `clk_count`=0 and `bit_index`=0.
  - IDLE: on a start edge, go to START with `clk_count`←0. A line held low without an edge never starts a frame, so a break or a post-reset low line is ignored.
  - START: counts to HALF-1 (HALF = CLKS_PER_BIT/2, integer), then samples `rx_s`.
    - 1: false start; go to IDLE with no outputs changed.
    - 0: go to DATA with `clk_count`←0 and `bit_index`←0.
  - DATA: at `clk_count`=CLKS_PER_BIT-1, shift `rx_s` into the MSB of the shift register (shift right) and reset `clk_count`. After the 8th bit (`bit_index`=7), go to STOP; otherwise increment `bit_index`.
  - STOP: at `clk_count`=CLKS_PER_BIT-1, sample `rx_s`, then return to IDLE in that same transition (mid-stop-bit, for resync margin).
    - 1: `data`←shift register and `data_valid`←1.
    - 0: pulse `frame_err` for one cycle; `data`, `data_valid` and `overrun` are unchanged.
- Handshake:
  - `data_ack` while `data_valid`=1 clears `data_valid` and `overrun` on the next edge.
  - `data_ack` while `data_valid`=0 is ignored.
- Overrun: a good stop bit while `data_valid`=1 and `data_ack`=0 sets `overrun`←1, and `data` is overwritten with the new byte.
- Simultaneous good stop bit and `data_ack`: the new byte wins. `data_valid` stays 1 with the new data, and `overrun` is cleared, not set.
- Reset mid-frame: everything returns to reset values immediately and the partial byte is discarded. Reception resumes only on a fresh start edge after `rst_n` deasserts.

## Timing
- Input latency: 2 cycles through the synchroniser plus 1 for edge detect. START is entered 3 edges after `rx` falls.
- From START entry to `data_valid` rising: HALF + 9·CLKS_PER_BIT cycles.
- `frame_err` asserts on the same edge `data_valid` would have.
- `busy` rises on START entry and falls on the IDLE return edge.
- Back-to-back frames: a start bit that begins up to half a bit after the nominal stop-bit end is caught.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE=0, START=1, DATA=2, STOP=3, 2 bits), shared with the transmitter;
  - `DEFAULT_CLKS_PER_BIT`=5208;
  - data width 8.
- Sub-module `sync_2ff`: 2-flop synchroniser with a reset value parameter, reusable for other external inputs.
- The counter, shift register, FSM and handshake live in `uart_rx` itself.

## Test plan
Use CLKS_PER_BIT=16 unless stated otherwise.
- Send 0xA5 at the correct baud → `data`=0xA5, `data_valid`=1 exactly HALF+9·16 cycles after START entry, and `frame_err`=0. Then pulse `data_ack` → `data_valid`=0 the next cycle.
- Drive a 5-cycle low glitch on idle `rx` → `busy` pulses for about 8 cycles; `data_valid` and `frame_err` stay 0.
- Send 0x3C with the stop bit driven low, then hold `rx` low 100 cycles → `frame_err` pulses exactly once, `data`/`data_valid` are unchanged, and no new frame starts until `rx` goes high then low.
- Send 0x11 then 0x22 with no ack → `data`=0x22 and `overrun`=1. Ack → `data_valid`=0 and `overrun`=0. Then send 0x33 with the ack on the completion edge → `data`=0x33, `data_valid`=1, `overrun`=0.
- Assert `rst_n`=0 at bit 4 of 0xF0, release, then send 0x5A → the outputs read reset values during reset, then `data`=0x5A with no error.
- Loopback from the existing transmitter at the default CLKS_PER_BIT with 0x00, 0xFF, 0x55 back-to-back → all three bytes are received in order with no `frame_err`.
